// File: rtl/factorial_pkg.sv
// Shared types and constants for the sequential factorial engine.
package factorial_pkg;

  localparam int unsigned N_W = 4;
  localparam int unsigned F_W = 16;
  localparam int unsigned P_W = N_W + F_W;

  localparam logic [F_W-1:0] ONE = 16'd1;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_e;

endpackage

// File: rtl/factorial_mul16x4.sv
// Combinational 16x4 unsigned multiplier with a full 20-bit product.
module factorial_mul16x4
  import factorial_pkg::*;
(
  input  logic [F_W-1:0] a,
  input  logic [N_W-1:0] b,
  output logic [P_W-1:0] p
);

  assign p = P_W'(a) * P_W'(b);

endmodule

// File: rtl/factorial_unit.sv
// Iterative n! engine, one multiply per clock, level-start/done handshake.
// Optional FACTORIAL_OVERFLOW_EN adds the overflow port and saturates fact to 16'hFFFF.
module factorial_unit
  import factorial_pkg::*;
(
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N_W-1:0] data1,
  output logic           done,
  output logic [F_W-1:0] fact
`ifdef FACTORIAL_OVERFLOW_EN
  ,
  output logic           overflow
`endif
);

  state_e         state_q, state_d;
  logic [N_W-1:0] cnt_q, cnt_d;
  logic [F_W-1:0] acc_q, acc_d;
  logic [F_W-1:0] fact_q, fact_d;
  logic [P_W-1:0] prod;

`ifdef FACTORIAL_OVERFLOW_EN
  logic ovf_flag_q, ovf_flag_d;
  logic ovf_q, ovf_d;
`else
  // High product bits only matter when saturation is built in.
  logic unused_prod_hi;
  assign unused_prod_hi = ^prod[P_W-1:F_W];
`endif

  factorial_mul16x4 u_mul (
    .a (acc_q),
    .b (cnt_q),
    .p (prod)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    fact_d  = fact_q;
`ifdef FACTORIAL_OVERFLOW_EN
    ovf_flag_d = ovf_flag_q;
    ovf_d      = ovf_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d   = data1;
          acc_d   = ONE;
          state_d = CALC;
`ifdef FACTORIAL_OVERFLOW_EN
          ovf_flag_d = 1'b0;
          ovf_d      = 1'b0;
`endif
        end
      end
      CALC: begin
        // cnt of 0 or 1 finishes at once, so 0! and 1! both yield acc=1.
        if (cnt_q <= N_W'(1)) begin
          fact_d  = acc_q;
          state_d = DONE;
`ifdef FACTORIAL_OVERFLOW_EN
          if (ovf_flag_q) begin
            fact_d = '1;
          end
          ovf_d = ovf_flag_q;
`endif
        end else begin
          acc_d = prod[F_W-1:0];
          cnt_d = cnt_q - N_W'(1);
`ifdef FACTORIAL_OVERFLOW_EN
          if (|prod[P_W-1:F_W]) begin
            ovf_flag_d = 1'b1;
          end
`endif
        end
      end
      DONE: begin
        if (!start) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= ONE;
      fact_q  <= '0;
`ifdef FACTORIAL_OVERFLOW_EN
      ovf_flag_q <= 1'b0;
      ovf_q      <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      fact_q  <= fact_d;
`ifdef FACTORIAL_OVERFLOW_EN
      ovf_flag_q <= ovf_flag_d;
      ovf_q      <= ovf_d;
`endif
    end
  end

  assign done = (state_q == DONE);
  assign fact = fact_q;
`ifdef FACTORIAL_OVERFLOW_EN
  assign overflow = ovf_q;
`endif

endmodule

// File: tb/tb_factorial_unit.sv
// Directed bench for factorial_unit; expected results queued at issue, popped at done.
module tb_factorial_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  data1;
  logic        done;
  logic [15:0] fact;
  logic        overflow;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [3:0]  n;
    logic [15:0] fact;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  factorial_unit dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .data1    (data1),
    .done     (done),
    .fact     (fact)
`ifdef FACTORIAL_OVERFLOW_EN
    ,
    .overflow (overflow)
`endif
  );

`ifndef FACTORIAL_OVERFLOW_EN
  assign overflow = 1'b0;
`endif

  function automatic exp_t model(input logic [3:0] n);
    exp_t        m;
    logic [19:0] p;
    logic [15:0] acc = 16'd1;
    logic        of  = 1'b0;
    for (int i = int'(n); i > 1; i--) begin
      p = 20'(acc) * 20'(i);
      if (p[19:16] != 4'd0) of = 1'b1;
      acc = p[15:0];
    end
`ifdef FACTORIAL_OVERFLOW_EN
    if (of) acc = 16'hFFFF;
`else
    of = 1'b0;
`endif
    m.n    = n;
    m.fact = acc;
    m.ovf  = of;
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // hold: cycles after issue before start drops; toggle: disturb inputs during CALC.
  task automatic do_op(input logic [3:0] n, input int hold, input bit toggle);
    exp_t e;
    int   cyc;
    bit   got;
    int   lat;
    @(negedge clk);
    data1 = n;
    start = 1'b1;
    sb.push_back(model(n));
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 40) begin
      @(posedge clk);
      cyc++;
      #1;
      if (done) begin
        got = 1'b1;
      end else begin
        if (cyc >= hold) start = 1'b0;
        if (toggle) begin
          data1 = data1 ^ 4'hF;
          start = cyc[0];
        end
      end
    end
    lat = (n > 4'd1) ? int'(n) : 1;
    chk($sformatf("done_seen n=%0d", n), 32'(got), 32'd1);
    chk($sformatf("latency n=%0d", n), 32'(cyc), 32'(lat + 1));
    chk($sformatf("sb_depth n=%0d", n), 32'(sb.size()), 32'd1);
    e = sb.pop_front();
    chk($sformatf("fact n=%0d", e.n), 32'(fact), 32'(e.fact));
`ifdef FACTORIAL_OVERFLOW_EN
    chk($sformatf("overflow n=%0d", e.n), 32'(overflow), 32'(e.ovf));
`endif
    if (start) begin
      repeat (2) begin
        @(posedge clk);
        #1;
        chk($sformatf("done_held n=%0d", n), 32'(done), 32'd1);
      end
      start = 1'b0;
    end
    @(posedge clk);
    #1;
    chk($sformatf("done_drop n=%0d", n), 32'(done), 32'd0);
    @(posedge clk);
    #1;
    chk($sformatf("no_restart n=%0d", n), 32'(done), 32'd0);
    chk($sformatf("fact_hold n=%0d", n), 32'(fact), 32'(e.fact));
  endtask

  initial begin
    bit seen;
    reset = 1'b1;
    start = 1'b0;
    data1 = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_done", 32'(done), 32'd0);
    chk("reset_fact", 32'(fact), 32'd0);
    chk("reset_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    do_op(4'd6, 4, 1'b0);
    do_op(4'd0, 1, 1'b0);
    do_op(4'd1, 1, 1'b0);
    do_op(4'd8, 1, 1'b0);
    do_op(4'd9, 1, 1'b0);
    do_op(4'd15, 1, 1'b0);

    // Abort n=7 with reset on its third CALC cycle.
    @(negedge clk);
    data1 = 4'd7;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_done", 32'(done), 32'd0);
    chk("abort_fact", 32'(fact), 32'd0);
    chk("abort_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 32'd0);

    do_op(4'd5, 1, 1'b0);
    do_op(4'd4, 1, 1'b1);
    do_op(4'd3, 100, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
